// File: rtl/aud_pkg.sv
// Shared types and constants for the audio record/playback slice.
package aud_pkg;

  localparam int unsigned AUD_DATA_W  = 16;
  localparam int unsigned SRAM_ADDR_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LRC,
    SKIP,
    SHIFT,
    WRITE,
    PAUSED
  } rec_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings the codec I2S pins into the system clock domain and flags BCLK rising edges.
module i2s_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic bclk,
  input  logic lrck,
  input  logic dat,
  output logic bclk_rise,
  output logic lrck_s,
  output logic dat_s
);

  logic [1:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic [1:0] dat_sync;
  logic       bclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      lrck_sync <= {lrck_sync[0], lrck};
      dat_sync  <= {dat_sync[0], dat};
      bclk_prev <= bclk_sync[1];
    end
  end

  // LRCK/DAT share BCLK's synchroniser depth so they stay aligned with bclk_rise.
  assign bclk_rise = bclk_sync[1] & ~bclk_prev;
  assign lrck_s    = lrck_sync[1];
  assign dat_s     = dat_sync[1];

endmodule

// File: rtl/aud_recorder.sv
// Captures left-channel I2S ADC samples and writes them to consecutive SRAM words.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int unsigned         ADDR_W   = SRAM_ADDR_W,
  parameter int unsigned         DATA_W   = AUD_DATA_W,
  parameter logic [ADDR_W-1:0]   ADDR_MAX = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_aud_bclk,
  input  logic              i_aud_lrck,
  input  logic              i_aud_adcdat,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr,
  output logic              o_recording,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_last_addr
);

  localparam int unsigned         CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0]   FULL_LAST = (ADDR_MAX == {ADDR_W{1'b1}}) ? {ADDR_W{1'b1}}
                                                                          : ADDR_MAX + ADDR_W'(1);

  rec_state_t          state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [ADDR_W-1:0]   last, last_n;
  logic                full, full_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                lrck_prev;
  logic                bclk_rise, lrck_s, dat_s;
  logic                lrck_fall;

  i2s_sync_edge u_sync (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .bclk      (i_aud_bclk),
    .lrck      (i_aud_lrck),
    .dat       (i_aud_adcdat),
    .bclk_rise (bclk_rise),
    .lrck_s    (lrck_s),
    .dat_s     (dat_s)
  );

  assign lrck_fall = bclk_rise & lrck_prev & ~lrck_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr      <= '0;
      last      <= '0;
      full      <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      lrck_prev <= 1'b0;
    end else begin
      addr  <= addr_n;
      last  <= last_n;
      full  <= full_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      if (bclk_rise) lrck_prev <= lrck_s;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    last_n  = last;
    full_n  = full;
    shreg_n = shreg;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (i_start) begin
          addr_n  = '0;
          full_n  = 1'b0;
          state_n = WAIT_LRC;
        end
      end
      WAIT_LRC, SKIP, SHIFT: begin
        if (i_stop) begin
          last_n  = addr;
          state_n = IDLE;
        end else if (i_pause) begin
          state_n = PAUSED;
        end else if (state == WAIT_LRC) begin
          if (lrck_fall) state_n = SKIP;
        end else if (state == SKIP) begin
          if (bclk_rise) begin
            cnt_n   = '0;
            state_n = SHIFT;
          end
        end else if (bclk_rise) begin
          shreg_n = {shreg[DATA_W-2:0], dat_s};
          cnt_n   = cnt + 1'b1;
          if (cnt == LAST_BIT) state_n = WRITE;
        end
      end
      WRITE: begin
        // The strobe always completes; a stop here only changes where we go next.
        if (addr == ADDR_MAX) begin
          full_n  = 1'b1;
          last_n  = FULL_LAST;
          state_n = IDLE;
        end else begin
          addr_n = addr + 1'b1;
          if (i_stop) begin
            last_n  = addr + 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_LRC;
          end
        end
      end
      PAUSED: begin
        if (i_stop) begin
          last_n  = addr;
          state_n = IDLE;
        end else if (i_start) begin
          state_n = WAIT_LRC;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_address   = addr;
  assign o_data      = shreg;
  assign o_wr        = (state == WRITE);
  assign o_recording = (state == WAIT_LRC) || (state == SKIP) ||
                       (state == SHIFT)    || (state == WRITE);
  assign o_full      = full;
  assign o_last_addr = last;

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder: I2S frames in, expected SRAM writes from a mode-level model.
module tb_aud_recorder;

  localparam int unsigned       AW   = 20;
  localparam int unsigned       DW   = 16;
  localparam logic [AW-1:0]     AMAX = 20'd3;

  logic          i_clk, i_rst_n, i_start, i_pause, i_stop;
  logic          i_aud_bclk, i_aud_lrck, i_aud_adcdat;
  logic [AW-1:0] o_address, o_last_addr;
  logic [DW-1:0] o_data;
  logic          o_wr, o_recording, o_full;

  aud_recorder #(.ADDR_W(AW), .DATA_W(DW), .ADDR_MAX(AMAX)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_pause      (i_pause),
    .i_stop       (i_stop),
    .i_aud_bclk   (i_aud_bclk),
    .i_aud_lrck   (i_aud_lrck),
    .i_aud_adcdat (i_aud_adcdat),
    .o_address    (o_address),
    .o_data       (o_data),
    .o_wr         (o_wr),
    .o_recording  (o_recording),
    .o_full       (o_full),
    .o_last_addr  (o_last_addr)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  longint t_bit16 = 0;

  // Model: 0 idle, 1 recording, 2 paused
  int          m_mode = 0;
  longint      m_addr = 0;
  longint      m_last = 0;
  bit          m_full = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got write addr %0h data %0h expected none at %0t",
                 o_address, o_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", o_address, mon_e.addr);
        chk("wr_data", o_data, mon_e.data);
        chk("wr_latency_cycles", ($time - t_bit16 + 5) / 10, 3);
      end
    end
  end

  function automatic longint sat_next(input longint a);
    longint top = (longint'(1) << AW) - 1;
    return (a >= top) ? top : a + 1;
  endfunction

  task automatic model_ctrl(input bit s, input bit p, input bit t);
    if (t) begin
      if (m_mode != 0) begin
        m_last = m_addr;
        m_mode = 0;
      end
    end else if (p) begin
      if (m_mode == 1) m_mode = 2;
    end else if (s) begin
      if (m_mode == 0) begin
        m_addr = 0;
        m_full = 1'b0;
        m_mode = 1;
      end else if (m_mode == 2) begin
        m_mode = 1;
      end
    end
  endtask

  task automatic model_word(input logic [DW-1:0] w);
    exp_q.push_back({AW'(m_addr), w});
    if (m_addr == longint'(AMAX)) begin
      m_full = 1'b1;
      m_last = sat_next(longint'(AMAX));
      m_mode = 0;
    end else begin
      m_addr++;
    end
  endtask

  // Leaves time at 2 mod 5 ns so BCLK edges never coincide with i_clk edges.
  task automatic ctrl(input bit s, input bit p, input bit t);
    @(negedge i_clk);
    i_start = s;
    i_pause = p;
    i_stop  = t;
    @(negedge i_clk);
    i_start = 1'b0;
    i_pause = 1'b0;
    i_stop  = 1'b0;
    model_ctrl(s, p, t);
    #2;
  endtask

  task automatic reset_mid();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_outputs", {o_address, o_data, o_wr, o_recording, o_full, o_last_addr}, 0);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b1;
    m_mode = 0;
    m_addr = 0;
    m_last = 0;
    m_full = 1'b0;
  endtask

  task automatic do_ctrl(input int kind);
    case (kind)
      1: ctrl(1'b0, 1'b1, 1'b0);
      2: ctrl(1'b0, 1'b0, 1'b1);
      3: ctrl(1'b1, 1'b1, 1'b1);
      4: reset_mid();
      default: ;
    endcase
  endtask

  task automatic bclk_cycle(input logic lr, input logic d);
    i_aud_bclk   = 1'b0;
    i_aud_lrck   = lr;
    i_aud_adcdat = d;
    #35;
    i_aud_bclk = 1'b1;
    #35;
  endtask

  // Left word rides rises 2..17 after LRCK falls; the control fires before rise ctrl_at.
  task automatic send_frame(input logic [DW-1:0] left, input int ctrl_at, input int kind);
    for (int j = 0; j < 20; j++) begin
      i_aud_bclk   = 1'b0;
      i_aud_lrck   = 1'b0;
      i_aud_adcdat = (j >= 2 && j <= 17) ? left[17 - j] : 1'($urandom);
      #35;
      if (j == ctrl_at) do_ctrl(kind);
      if (j == 17) begin
        if (m_mode == 1) model_word(left);
        t_bit16 = $time;
      end
      i_aud_bclk = 1'b1;
      #35;
    end
    for (int j = 0; j < 20; j++) bclk_cycle(1'b1, 1'($urandom));
  endtask

  task automatic check_status(input string tag);
    @(negedge i_clk);
    chk({tag, "_recording"}, o_recording, (m_mode == 1) ? 1 : 0);
    chk({tag, "_full"}, o_full, m_full);
    chk({tag, "_last_addr"}, o_last_addr, m_last);
    #2;
  endtask

  initial begin
    int op;
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_pause      = 1'b0;
    i_stop       = 1'b0;
    i_aud_bclk   = 1'b0;
    i_aud_lrck   = 1'b1;
    i_aud_adcdat = 1'b0;
    @(negedge i_clk);
    chk("reset_outputs", {o_address, o_data, o_wr, o_recording, o_full, o_last_addr}, 0);
    #2;
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) bclk_cycle(1'b1, 1'b0);

    // Single capture, then stop
    ctrl(1'b1, 1'b0, 1'b0);
    check_status("start");
    send_frame(16'hA5C3, -1, 0);
    check_status("after_a5c3");
    ctrl(1'b0, 1'b0, 1'b1);
    check_status("stop_one");

    // Four consecutive words fill addresses 0..3 (last one hits ADDR_MAX)
    ctrl(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) send_frame(DW'(k), -1, 0);
    ctrl(1'b0, 1'b0, 1'b1);
    check_status("four_frames");

    // Pause after 8 bits of the third word, resume, BEEF lands at address 2
    ctrl(1'b1, 1'b0, 1'b0);
    send_frame(16'h1111, -1, 0);
    send_frame(16'h2222, -1, 0);
    send_frame(16'h3333, 10, 1);
    check_status("paused");
    ctrl(1'b1, 1'b0, 1'b0);
    send_frame(16'hBEEF, -1, 0);
    ctrl(1'b0, 1'b0, 1'b1);
    check_status("beef_stop");

    // Five frames into four words: the fifth is ignored
    ctrl(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_frame(DW'($urandom), -1, 0);
    check_status("full");
    ctrl(1'b1, 1'b0, 1'b0);
    check_status("full_cleared");
    send_frame(16'h5A5A, -1, 0);

    // Simultaneous start+pause+stop mid-word
    send_frame(16'hDEAD, 12, 3);
    check_status("simul");

    // Asynchronous reset mid-word
    ctrl(1'b1, 1'b0, 1'b0);
    send_frame(16'hC0DE, 9, 4);
    check_status("post_reset");

    // Randomised mix of frames and controls
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1, 2: begin
          if ($urandom_range(0, 3) == 0)
            send_frame(DW'($urandom), $urandom_range(1, 17), $urandom_range(1, 2));
          else
            send_frame(DW'($urandom), -1, 0);
        end
        3: ctrl(1'b1, 1'b0, 1'b0);
        4: ctrl(1'b0, 1'b1, 1'b0);
        default: ctrl(1'b0, 1'b0, 1'b1);
      endcase
      check_status("rand");
    end

    for (int k = 0; k < 4; k++) bclk_cycle(1'b1, 1'b0);
    chk("writes_outstanding", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
